// File: rtl/qlal4_intc_pkg.sv
// Shared constants for the fabric interrupt controller: register offsets,
// register data width and the bank-count helper.
package qlal4_intc_pkg;

  localparam int REG_DW = 8;

  localparam logic [1:0] INTC_STATUS   = 2'd0;
  localparam logic [1:0] INTC_ENABLE   = 2'd1;
  localparam logic [1:0] INTC_MODE     = 2'd2;
  localparam logic [1:0] INTC_POLARITY = 2'd3;

  // Number of 8-bit register banks needed to cover n channels.
  function automatic int nbank(input int n);
    return (n + REG_DW - 1) / REG_DW;
  endfunction

endpackage

// File: rtl/qlal4_intc_sync_edge.sv
// Per-channel input conditioning: multi-flop synchroniser, one delay flop and
// polarity-aware edge / level extraction.
module qlal4_intc_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic reg_clk_int,
  input  logic RESET_n,
  input  logic int_raw,
  input  logic mode,
  input  logic pol,
  output logic set_pulse,
  output logic level
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   s_d;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge reg_clk_int or negedge RESET_n) begin
    if (!RESET_n) begin
      sync_q <= '0;
      s_d    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], int_raw};
      s_d    <= s;
    end
  end

  // Detection uses the raw synchronised line, so a polarity change alone never fires.
  assign set_pulse = mode & (pol ? (~s & s_d) : (s & ~s_d));
  assign level     = s ^ pol;

endmodule

// File: rtl/qlal4_interrupt_controller.sv
// Parametrised fabric interrupt controller: banked 8-bit register file,
// sticky/level pending logic, registered read port and fixed-priority request.
module qlal4_interrupt_controller
  import qlal4_intc_pkg::*;
#(
  parameter int  N_INT       = 8,
  parameter int  SYNC_STAGES = 2,
  localparam int NBANK       = nbank(N_INT),
  localparam int AW          = $clog2(NBANK) + 2,
  localparam int IDW         = (N_INT > 1) ? $clog2(N_INT) : 1
) (
  input  logic              reg_clk_int,
  input  logic              RESET_n,
  input  logic [N_INT-1:0]  int_i,
  input  logic              af_fpga_int_en,
  input  logic [AW-1:0]     reg_addr_int,
  input  logic              reg_wr_en_int,
  input  logic [REG_DW-1:0] reg_wr_data_int,
  input  logic              reg_rd_en_int,
  output logic [REG_DW-1:0] reg_rd_data_int,
  output logic              int_o,
  output logic [IDW-1:0]    int_id_o
);

  localparam int NPAD = NBANK * REG_DW;

  logic [N_INT-1:0] pending;
  logic [N_INT-1:0] enable;
  logic [N_INT-1:0] mode;
  logic [N_INT-1:0] pol;

  logic [N_INT-1:0] set_pulse;
  logic [N_INT-1:0] level;

  logic [N_INT-1:0] wdat;
  logic [N_INT-1:0] bank_hit;
  logic [N_INT-1:0] w1c;
  logic [N_INT-1:0] en_we;
  logic [N_INT-1:0] mode_we;
  logic [N_INT-1:0] pol_we;
  logic [N_INT-1:0] enable_nxt;
  logic [N_INT-1:0] mode_nxt;
  logic [N_INT-1:0] pol_nxt;
  logic [N_INT-1:0] mode_to_edge;
  logic [N_INT-1:0] pending_nxt;
  logic [N_INT-1:0] act;

  logic [1:0]        offset;
  int                bank_idx;
  logic              wr_status;
  logic              wr_enable;
  logic              wr_mode;
  logic              wr_pol;
  logic [NPAD-1:0]   pend_pad;
  logic [NPAD-1:0]   enable_pad;
  logic [NPAD-1:0]   mode_pad;
  logic [NPAD-1:0]   pol_pad;
  logic [REG_DW-1:0] rd_mux;
  logic [IDW-1:0]    id_nxt;

  for (genvar c = 0; c < N_INT; c++) begin : g_ch
    qlal4_intc_sync_edge #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge (
      .reg_clk_int(reg_clk_int),
      .RESET_n    (RESET_n),
      .int_raw    (int_i[c]),
      .mode       (mode[c]),
      .pol        (pol[c]),
      .set_pulse  (set_pulse[c]),
      .level      (level[c])
    );
  end

  assign offset   = reg_addr_int[1:0];
  assign bank_idx = int'(reg_addr_int >> 2);

  assign wr_status = reg_wr_en_int && (offset == INTC_STATUS);
  assign wr_enable = reg_wr_en_int && (offset == INTC_ENABLE);
  assign wr_mode   = reg_wr_en_int && (offset == INTC_MODE);
  assign wr_pol    = reg_wr_en_int && (offset == INTC_POLARITY);

  // Spread the 8-bit write data over all channels of the addressed bank.
  always_comb begin
    wdat     = '0;
    bank_hit = '0;
    for (int c = 0; c < N_INT; c++) begin
      wdat[c]     = reg_wr_data_int[c % REG_DW];
      bank_hit[c] = (bank_idx == c / REG_DW);
    end
  end

  assign w1c     = {N_INT{wr_status}} & bank_hit & wdat;
  assign en_we   = {N_INT{wr_enable}} & bank_hit;
  assign mode_we = {N_INT{wr_mode}}   & bank_hit;
  assign pol_we  = {N_INT{wr_pol}}    & bank_hit;

  assign enable_nxt = (enable & ~en_we)   | (wdat & en_we);
  assign mode_nxt   = (mode   & ~mode_we) | (wdat & mode_we);
  assign pol_nxt    = (pol    & ~pol_we)  | (wdat & pol_we);

  assign mode_to_edge = mode_nxt & ~mode;

  // Edge channels: a new event beats a same-cycle W1C. Level channels follow the line.
  assign pending_nxt = ((mode & (set_pulse | (pending & ~w1c))) | (~mode & level))
                     & ~mode_to_edge;

  assign act = pending & enable;

  always_comb begin
    id_nxt = '0;
    for (int c = N_INT - 1; c >= 0; c--) begin
      if (act[c]) id_nxt = IDW'(c);
    end
  end

  always_comb begin
    pend_pad   = NPAD'(pending);
    enable_pad = NPAD'(enable);
    mode_pad   = NPAD'(mode);
    pol_pad    = NPAD'(pol);
    rd_mux     = '0;
    for (int b = 0; b < NBANK; b++) begin
      if (bank_idx == b) begin
        case (offset)
          INTC_STATUS:   rd_mux = pend_pad[b*REG_DW +: REG_DW];
          INTC_ENABLE:   rd_mux = enable_pad[b*REG_DW +: REG_DW];
          INTC_MODE:     rd_mux = mode_pad[b*REG_DW +: REG_DW];
          default:       rd_mux = pol_pad[b*REG_DW +: REG_DW];
        endcase
      end
    end
  end

  always_ff @(posedge reg_clk_int or negedge RESET_n) begin
    if (!RESET_n) begin
      pending         <= '0;
      enable          <= '0;
      mode            <= '0;
      pol             <= '0;
      reg_rd_data_int <= '0;
      int_o           <= 1'b0;
      int_id_o        <= '0;
    end else begin
      pending  <= pending_nxt;
      enable   <= enable_nxt;
      mode     <= mode_nxt;
      pol      <= pol_nxt;
      if (reg_rd_en_int) reg_rd_data_int <= rd_mux;
      int_o    <= (|act) & af_fpga_int_en;
      int_id_o <= id_nxt;
    end
  end

endmodule

// File: tb/tb_qlal4_interrupt_controller.sv
// Directed-vector bench for qlal4_interrupt_controller: an 8-channel and a
// 20-channel instance share clock, reset and the register bus.
module tb_qlal4_interrupt_controller;

  localparam int SS = 2;

  logic        clk;
  logic        rst_n;
  logic        en_g;
  logic [7:0]  int8;
  logic [19:0] int20;
  logic [3:0]  addr;
  logic [7:0]  wdata;
  logic        wr8, rd8, wr20, rd20;
  logic [7:0]  rdata8, rdata20;
  logic        io8, io20;
  logic [2:0]  id8;
  logic [4:0]  id20;

  int n_vec = 0;
  int n_err = 0;

  qlal4_interrupt_controller #(.N_INT(8), .SYNC_STAGES(SS)) dut8 (
    .reg_clk_int    (clk),
    .RESET_n        (rst_n),
    .int_i          (int8),
    .af_fpga_int_en (en_g),
    .reg_addr_int   (addr[1:0]),
    .reg_wr_en_int  (wr8),
    .reg_wr_data_int(wdata),
    .reg_rd_en_int  (rd8),
    .reg_rd_data_int(rdata8),
    .int_o          (io8),
    .int_id_o       (id8)
  );

  qlal4_interrupt_controller #(.N_INT(20), .SYNC_STAGES(SS)) dut20 (
    .reg_clk_int    (clk),
    .RESET_n        (rst_n),
    .int_i          (int20),
    .af_fpga_int_en (en_g),
    .reg_addr_int   (addr),
    .reg_wr_en_int  (wr20),
    .reg_wr_data_int(wdata),
    .reg_rd_en_int  (rd20),
    .reg_rd_data_int(rdata20),
    .int_o          (io20),
    .int_id_o       (id20)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wr(input bit sel20, input logic [3:0] a, input logic [7:0] d);
    addr  = a;
    wdata = d;
    if (sel20) wr20 = 1'b1;
    else       wr8  = 1'b1;
    tick();
    wr8  = 1'b0;
    wr20 = 1'b0;
  endtask

  task automatic rdchk(input bit sel20, input logic [3:0] a, input string tag,
                       input logic [7:0] exp);
    addr = a;
    if (sel20) rd20 = 1'b1;
    else       rd8  = 1'b1;
    tick();
    rd8  = 1'b0;
    rd20 = 1'b0;
    chk(tag, sel20 ? rdata20 : rdata8, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; en_g = 1'b1; int8 = '0; int20 = '0;
    addr = '0; wdata = '0; wr8 = 0; rd8 = 0; wr20 = 0; rd20 = 0;

    // 1. reset state
    #12;
    chk("rst_int8", io8, 0);
    chk("rst_id8", id8, 0);
    chk("rst_rd8", rdata8, 0);
    chk("rst_int20", io20, 0);
    chk("rst_id20", id20, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    rdchk(0, 4'h0, "rst_status", 8'h00);
    rdchk(0, 4'h1, "rst_enable", 8'h00);
    rdchk(0, 4'h2, "rst_mode", 8'h00);
    rdchk(0, 4'h3, "rst_pol", 8'h00);

    // 2. edge, rising, channel 0
    wr(0, 4'h2, 8'h01);
    wr(0, 4'h1, 8'h01);
    int8[0] = 1'b1;
    repeat (SS + 1) tick();
    int8[0] = 1'b0;
    chk("t2_int_early", io8, 0);
    tick();
    chk("t2_int_on", io8, 1);
    chk("t2_id", id8, 0);
    rdchk(0, 4'h0, "t2_status", 8'h01);
    wr(0, 4'h0, 8'h01);
    chk("t2_int_hold", io8, 1);
    tick();
    chk("t2_int_clr", io8, 0);

    // 3. priority between channels 2 and 5
    wr(0, 4'h2, 8'h25);
    wr(0, 4'h1, 8'h25);
    int8[5] = 1'b1;
    int8[2] = 1'b1;
    repeat (SS + 2) tick();
    int8[5] = 1'b0;
    int8[2] = 1'b0;
    chk("t3_int", io8, 1);
    chk("t3_id2", id8, 2);
    wr(0, 4'h0, 8'h04);
    tick();
    chk("t3_id5", id8, 5);
    chk("t3_int5", io8, 1);
    wr(0, 4'h0, 8'h20);
    tick();
    chk("t3_int_none", io8, 0);
    chk("t3_id_none", id8, 0);

    // 4. level mode, active-low, channel 3
    wr(0, 4'h3, 8'h08);
    wr(0, 4'h1, 8'h08);
    tick();
    chk("t4_int", io8, 1);
    chk("t4_id", id8, 3);
    rdchk(0, 4'h0, "t4_status", 8'h08);
    wr(0, 4'h0, 8'h08);
    tick();
    tick();
    chk("t4_w1c_ignored", io8, 1);
    rdchk(0, 4'h0, "t4_status_kept", 8'h08);
    int8[3] = 1'b1;
    repeat (SS + 2) tick();
    chk("t4_int_off", io8, 0);
    wr(0, 4'h1, 8'h01);
    wr(0, 4'h3, 8'h00);
    int8[3] = 1'b0;
    repeat (SS + 2) tick();

    // 5. set and W1C on the same edge; global enable
    int8[0] = 1'b1;
    tick();
    tick();
    wr(0, 4'h0, 8'h01);
    rdchk(0, 4'h0, "t5_set_wins", 8'h01);
    chk("t5_int", io8, 1);
    en_g = 1'b0;
    tick();
    tick();
    chk("t5_gen_off", io8, 0);
    rdchk(0, 4'h0, "t5_status_gen_off", 8'h01);
    en_g = 1'b1;
    int8[0] = 1'b0;
    wr(0, 4'h0, 8'h01);
    tick();
    chk("t5_clr", io8, 0);

    // 6. 20-channel instance: partial bank, empty bank, high channel, async reset
    wr(1, 4'h9, 8'hFF);
    rdchk(1, 4'h9, "t6_enable_b2", 8'h0F);
    wr(1, 4'hD, 8'hFF);
    rdchk(1, 4'hD, "t6_enable_b3", 8'h00);
    rdchk(1, 4'hC, "t6_status_b3", 8'h00);
    wr(1, 4'hA, 8'h08);
    rdchk(1, 4'hA, "t6_mode_b2", 8'h08);
    int20[19] = 1'b1;
    repeat (SS + 2) tick();
    chk("t6_int19", io20, 1);
    chk("t6_id19", id20, 19);
    rdchk(1, 4'h8, "t6_status_b2", 8'h08);
    int20[19] = 1'b0;
    repeat (SS + 1) tick();
    int20[19] = 1'b1;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_int", io20, 0);
    chk("t6_rst_id", id20, 0);
    chk("t6_rst_rd", rdata20, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    rdchk(1, 4'h9, "t6_rst_enable", 8'h00);
    rdchk(1, 4'hA, "t6_rst_mode", 8'h00);
    repeat (SS + 1) tick();
    rdchk(1, 4'h8, "t6_level_after_rst", 8'h08);
    chk("t6_int_after_rst", io20, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
